// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants.
// Register file geometry and the hardwired zero register index.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/writeback_regfile_if.sv
// MEM/WB entry, ID read ports and forwarding export.
// The master side is the pipeline; the slave side is the register file.
interface writeback_regfile_if
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] MEMtoWB_ReadData;
  logic [DATA_W-1:0] MEMtoWB_ALU_result;
  reg_addr_t         MEMtoWB_RegDest;
  logic              MEMtoWB_MemtoReg;
  logic              MEMtoWB_RegWrite;

  reg_addr_t         ID_rs;
  reg_addr_t         ID_rt;
  logic [DATA_W-1:0] ID_ReadData1;
  logic [DATA_W-1:0] ID_ReadData2;

  logic [DATA_W-1:0] WB_WriteData;
  reg_addr_t         WB_RegDest;
  logic              WB_RegWrite;

  modport master (
    output MEMtoWB_ReadData,
    output MEMtoWB_ALU_result,
    output MEMtoWB_RegDest,
    output MEMtoWB_MemtoReg,
    output MEMtoWB_RegWrite,
    output ID_rs,
    output ID_rt,
    input  ID_ReadData1,
    input  ID_ReadData2,
    input  WB_WriteData,
    input  WB_RegDest,
    input  WB_RegWrite
  );

  modport slave (
    input  MEMtoWB_ReadData,
    input  MEMtoWB_ALU_result,
    input  MEMtoWB_RegDest,
    input  MEMtoWB_MemtoReg,
    input  MEMtoWB_RegWrite,
    input  ID_rs,
    input  ID_rt,
    output ID_ReadData1,
    output ID_ReadData2,
    output WB_WriteData,
    output WB_RegDest,
    output WB_RegWrite
  );

endinterface

// File: rtl/regfile_array.sv
// Architectural register storage with synchronous clear.
// Raw read ports only; zero masking and bypass live in the stage.
module regfile_array
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int NR = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  reg_addr_t     waddr,
  input  logic [DW-1:0] wdata,
  input  reg_addr_t     raddr1,
  input  reg_addr_t     raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  logic [DW-1:0] regs [NR];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        regs[i] <= '0;
      end
    end else if (we && waddr != REG_ZERO) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: result select, commit, and ID read ports
// with same-cycle write-through so ID never sees stale data.
module writeback_regfile #(
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int NUM_REGS = mips_pkg::NUM_REGS
) (
  input logic                clk,
  input logic                rst,
  writeback_regfile_if.slave wb
);

  import mips_pkg::*;

  logic [DATA_W-1:0] wb_data;
  logic              we;
  logic [DATA_W-1:0] raw1;
  logic [DATA_W-1:0] raw2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  assign wb_data = wb.MEMtoWB_MemtoReg
                 ? wb.MEMtoWB_ReadData
                 : wb.MEMtoWB_ALU_result;

  assign we = rst
            & wb.MEMtoWB_RegWrite
            & (wb.MEMtoWB_RegDest != REG_ZERO);

  regfile_array #(
    .DW (DATA_W),
    .NR (NUM_REGS)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (wb.MEMtoWB_RegDest),
    .wdata  (wb_data),
    .raddr1 (wb.ID_rs),
    .raddr2 (wb.ID_rt),
    .rdata1 (raw1),
    .rdata2 (raw2)
  );

  // we implies dest != 0, so the two arms never overlap
  always_comb begin
    rd1 = raw1;
    unique case (1'b1)
      (wb.ID_rs == REG_ZERO):
        rd1 = '0;
      (we && wb.ID_rs == wb.MEMtoWB_RegDest):
        rd1 = wb_data;
      default: ;
    endcase
  end

  always_comb begin
    rd2 = raw2;
    unique case (1'b1)
      (wb.ID_rt == REG_ZERO):
        rd2 = '0;
      (we && wb.ID_rt == wb.MEMtoWB_RegDest):
        rd2 = wb_data;
      default: ;
    endcase
  end

  assign wb.ID_ReadData1 = rd1;
  assign wb.ID_ReadData2 = rd2;
  assign wb.WB_WriteData = wb_data;
  assign wb.WB_RegDest   = wb.MEMtoWB_RegDest;
  assign wb.WB_RegWrite  = we;

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage and architectural register file of the five-stage MIPS pipeline. Consumes the MEM/WB pipeline register outputs, selects load data or ALU result, and commits it to a 32×32 register file. Serves the two ID-stage read ports with same-cycle write-through bypass. Exports the committed writeback value for the forwarding unit.

## Interface
Parameters:
- DATA_W, 32, register/data width
- NUM_REGS, 32, register count; address width fixed at 5

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- MEMtoWB_ReadData  in  DATA_W  load data from MEM/WB register
- MEMtoWB_ALU_result  in  DATA_W  ALU result from MEM/WB register
- MEMtoWB_RegDest  in  5  destination register index
- MEMtoWB_MemtoReg  in  1  1 = write load data, 0 = write ALU result
- MEMtoWB_RegWrite  in  1  write request
- ID_rs  in  5  read port 1 address
- ID_rt  in  5  read port 2 address
- ID_ReadData1  out  DATA_W  read port 1 data
- ID_ReadData2  out  DATA_W  read port 2 data
- WB_WriteData  out  DATA_W  selected writeback value (to forwarding unit)
- WB_RegDest  out  5  MEMtoWB_RegDest passed through
- WB_RegWrite  out  1  effective write enable

## Operation
- WB_WriteData = MEMtoWB_MemtoReg ? MEMtoWB_ReadData : MEMtoWB_ALU_result; combinational.
- WB_RegWrite = rst & MEMtoWB_RegWrite & (MEMtoWB_RegDest != 0).
- Register 0 hardwired to zero: never stored, always reads 0, never bypassed.
- Commit: on rising clk with WB_RegWrite = 1, regs[MEMtoWB_RegDest] <= WB_WriteData. No other register changes.
- Read port n (addr A):
  - A == 0 → 0.
  - Else if WB_RegWrite and A == MEMtoWB_RegDest → WB_WriteData (write-through bypass).
  - Else → regs[A].
- Both ports addressing the same register return identical data, bypass included.
- Reset: rising clk with rst = 0 clears regs[1..31] to 0. Writes are suppressed in that cycle. While rst = 0, WB_RegWrite = 0 and reads return the stored array, so they show 0 after the first reset edge.
- Mid-operation reset discards any in-flight writeback. The first write after reset release commits normally on the first edge with rst = 1.
- No X propagation: all 31 registers have defined reset values.

## Timing
- Writeback mux, bypass and read ports: zero-cycle combinational paths.
- Commit latency: 1 edge. A value presented in cycle N is visible from the array in cycle N+1 and via bypass in cycle N.
- No handshake. A MEM/WB entry is consumed every cycle; stalls and bubbles arrive as MEMtoWB_RegWrite = 0.
- Output reset values: after the reset edge, ID_ReadData1/2 = 0 for any address. WB_RegWrite = 0 while rst = 0. WB_WriteData and WB_RegDest follow their inputs and are not registered.
- Back-to-back writes to the same register: last edge wins. A read in the cycle of the second write returns the second value.

## Structure
- Shared package mips_pkg: DATA_W, REG_ADDR_W = 5, NUM_REGS, REG_ZERO = 5'd0.
- One sub-module: regfile_array, holding storage, reset clear and the two raw read ports.
- Writeback mux, zero-register and bypass logic stay in writeback_regfile.

## Test plan
- Reset: pulse rst low 1 cycle after random writes → every address reads 0 on both ports, WB_RegWrite = 0 during reset.
- Select: MemtoReg = 1, ReadData = 0xDEADBEEF, ALU = 0x12345678, RegDest = 5, RegWrite = 1 → WB_WriteData = 0xDEADBEEF; next cycle ID_rs = 5 reads 0xDEADBEEF. Repeat with MemtoReg = 0 → 0x12345678.
- Bypass: write 0x0000_00AA to reg 9 with ID_rs = ID_rt = 9 in the same cycle → both ports show 0xAA before the edge. Prior content 0x55 is never seen.
- Zero register: RegWrite = 1, RegDest = 0, data 0xFFFFFFFF → WB_RegWrite = 0, reg 0 reads 0 in the same and next cycle.
- Disabled write: RegWrite = 0, RegDest = 3, data 0x77 → reg 3 keeps its prior value 0x11, no bypass.
- Reset mid-write: rst = 0 coinciding with a write of 0x99 to reg 7 → reg 7 = 0 after the edge. Write 0x99 again after release → reads 0x99 the following cycle.
